// File: rtl/inst_stage_sequencer.sv
// Instruction queue between prefetch and scheduler: classifies each word into a stage total
// and steps the head through its stages. Optional same-cycle bypass: INST_QUEUE_BYPASS_EN.
module inst_stage_sequencer #(
   parameter int         INST_BITS   = 16,
   parameter int         QUEUE_DEPTH = 2,
   parameter int         STAGE_BITS  = 2,
   parameter logic [3:0] CALL_CC     = 4'd15
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               in_valid,
   input  logic [INST_BITS-1:0]               in_inst,
   output logic                               in_ready,
   output logic                               cur_valid,
   output logic [INST_BITS-1:0]               cur_inst,
   output logic [STAGE_BITS-1:0]              cur_stage,
   output logic                               cur_pre_stage,
   output logic                               cur_last_stage,
   input  logic                               sc_done,
   input  logic                               sc_repeat,
   input  logic                               flush,
   output logic                               inst_done,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count
);

   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Index of the final stage (stage total minus one) for an instruction word.
   function automatic logic [STAGE_BITS-1:0] last_stage_of(input logic [INST_BITS-1:0] w);
      logic [STAGE_BITS-1:0] r;
      if ((w[15:12] == 4'd0) && (w[11:8] == CALL_CC)) begin
         r = STAGE_BITS'(1);
      end else if (w[15:6] == 10'b0010000001) begin
         r = STAGE_BITS'(1);
      end else begin
         r = '0;
      end
      return r;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == PTR_W'(QUEUE_DEPTH - 1)) begin
         r = '0;
      end else begin
         r = p + PTR_W'(1);
      end
      return r;
   endfunction

   logic [INST_BITS-1:0]  inst_mem_r [QUEUE_DEPTH];
   logic [STAGE_BITS-1:0] last_mem_r [QUEUE_DEPTH];
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic [STAGE_BITS-1:0] cur_stage_r;
   state_t                state_r;

   logic                  in_ready_s;
   logic                  push_s;
   logic                  byp_s;
   logic                  head_valid_s;
   logic [INST_BITS-1:0]  head_inst_s;
   logic [STAGE_BITS-1:0] head_last_idx_s;
   logic                  head_last_s;
   logic                  fire_s;
   logic                  pop_s;
   logic                  write_s;
   logic                  deq_s;
   logic [CNT_W-1:0]      count_nxt_s;
   logic [PTR_W-1:0]      rd_ptr_nxt_s;
   logic [PTR_W-1:0]      wr_ptr_nxt_s;
   logic [STAGE_BITS-1:0] stage_nxt_s;
   state_t                state_nxt_s;

   // Accept handshake and optional empty-queue bypass selection.
   always_comb begin
      in_ready_s = (count_r < CNT_W'(QUEUE_DEPTH)) && !flush;
      push_s     = in_valid && in_ready_s;
      byp_s      = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
      if ((state_r == ST_IDLE) && push_s) begin
         byp_s = 1'b1;
      end else begin
         byp_s = 1'b0;
      end
`endif
   end

   // Head selection and stage-completion decode.
   always_comb begin
      head_valid_s    = 1'b0;
      head_inst_s     = '0;
      head_last_idx_s = '0;
      if (byp_s) begin
         head_valid_s    = 1'b1;
         head_inst_s     = in_inst;
         head_last_idx_s = last_stage_of(in_inst);
      end else if (state_r == ST_RUN) begin
         head_valid_s    = 1'b1;
         head_inst_s     = inst_mem_r[rd_ptr_r];
         head_last_idx_s = last_mem_r[rd_ptr_r];
      end else begin
         head_valid_s    = 1'b0;
      end
      head_last_s = head_valid_s && (cur_stage_r == head_last_idx_s);
      fire_s      = head_valid_s && sc_done && !sc_repeat;
      pop_s       = fire_s && head_last_s;
      // a bypassed word that retires immediately never occupies a slot
      write_s     = push_s && !(byp_s && pop_s);
      deq_s       = pop_s && !byp_s;
   end

   // Occupancy and pointer update, including flush of everything behind the head.
   always_comb begin
      count_nxt_s  = count_r;
      rd_ptr_nxt_s = rd_ptr_r;
      wr_ptr_nxt_s = wr_ptr_r;
      if (deq_s) begin
         rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      if (flush) begin
         if ((count_r != '0) && !deq_s) begin
            count_nxt_s = CNT_W'(1);
         end else begin
            count_nxt_s = '0;
         end
         if (count_r != '0) begin
            wr_ptr_nxt_s = ptr_inc(rd_ptr_r);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
      end else begin
         case ({write_s, deq_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
         endcase
         if (write_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
      end
   end

   // Head FSM next state and stage index.
   always_comb begin
      state_nxt_s = state_r;
      stage_nxt_s = cur_stage_r;
      case (state_r)
         ST_IDLE: begin
            if (count_nxt_s != '0) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (count_nxt_s != '0) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
      if (pop_s) begin
         stage_nxt_s = '0;
      end else if (fire_s) begin
         stage_nxt_s = cur_stage_r + STAGE_BITS'(1);
      end else begin
         stage_nxt_s = cur_stage_r;
      end
   end

   // FSM state, stage index, pointers and occupancy registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cur_stage_r <= '0;
         rd_ptr_r    <= '0;
         wr_ptr_r    <= '0;
         count_r     <= '0;
      end else begin
         state_r     <= state_nxt_s;
         cur_stage_r <= stage_nxt_s;
         rd_ptr_r    <= rd_ptr_nxt_s;
         wr_ptr_r    <= wr_ptr_nxt_s;
         count_r     <= count_nxt_s;
      end
   end

   // Queue storage: word plus its precomputed final-stage index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            inst_mem_r[i] <= '0;
            last_mem_r[i] <= '0;
         end
      end else if (write_s) begin
         inst_mem_r[wr_ptr_r] <= in_inst;
         last_mem_r[wr_ptr_r] <= last_stage_of(in_inst);
      end
   end

   assign in_ready       = in_ready_s;
   assign cur_valid      = head_valid_s;
   assign cur_inst       = head_inst_s;
   assign cur_stage      = cur_stage_r;
   assign cur_last_stage = head_last_s;
   assign cur_pre_stage  = head_valid_s && !head_last_s;
   assign inst_done      = pop_s;
   assign queue_count    = count_r;

endmodule

// File: tb/tb_inst_stage_sequencer.sv
// Scoreboard bench for inst_stage_sequencer (depth 3): a queue-level reference model predicts
// every cycle's outputs; retirements are queued and checked by an independent monitor.
module tb_inst_stage_sequencer;
   localparam int QD = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_inst = 16'h0000;
   logic        in_ready;
   logic        cur_valid;
   logic [15:0] cur_inst;
   logic [1:0]  cur_stage;
   logic        cur_pre_stage;
   logic        cur_last_stage;
   logic        sc_done = 1'b0;
   logic        sc_repeat = 1'b0;
   logic        flush = 1'b0;
   logic        inst_done;
   logic [1:0]  queue_count;

   inst_stage_sequencer #(
      .INST_BITS(16), .QUEUE_DEPTH(QD), .STAGE_BITS(2), .CALL_CC(4'd15)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
      .cur_valid(cur_valid), .cur_inst(cur_inst), .cur_stage(cur_stage),
      .cur_pre_stage(cur_pre_stage), .cur_last_stage(cur_last_stage),
      .sc_done(sc_done), .sc_repeat(sc_repeat), .flush(flush),
      .inst_done(inst_done), .queue_count(queue_count)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [15:0] mq[$];
   int          mstage = 0;
   logic [15:0] sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int nst_of(input logic [15:0] w);
      if (w[15:12] == 4'd0 && w[11:8] == 4'd15) return 2;
      if (w[15:6] == 10'b0010000001) return 2;
      return 1;
   endfunction

   // One clock of stimulus: drive, predict and check outputs, then advance the model.
   task automatic step(input logic v, input logic [15:0] w, input logic d, input logic r,
                       input logic f);
      logic [15:0] hq[$];
      logic rdy, push, byp, hv, last, fire, ret;
      @(posedge clk);
      #1;
      in_valid = v; in_inst = w; sc_done = d; sc_repeat = r; flush = f;
      rdy  = (mq.size() < QD) && !f;
      push = v && rdy;
      hq   = mq;
      byp  = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
      if (mq.size() == 0 && push) begin
         hq.push_back(w);
         byp = 1'b1;
      end
`endif
      hv   = hq.size() > 0;
      last = hv && (mstage == nst_of(hv ? hq[0] : 16'h0000) - 1);
      fire = hv && d && !r;
      ret  = fire && last;
      if (ret) sbq.push_back(hq[0]);
      #3;
      chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      chk("cur_valid", {31'd0, cur_valid}, {31'd0, hv});
      chk("queue_count", {30'd0, queue_count}, mq.size());
      chk("cur_stage", {30'd0, cur_stage}, hv ? mstage : 0);
      chk("cur_last_stage", {31'd0, cur_last_stage}, {31'd0, last});
      chk("cur_pre_stage", {31'd0, cur_pre_stage}, {31'd0, hv && !last});
      chk("inst_done", {31'd0, inst_done}, {31'd0, ret});
      chk("cur_inst", {16'd0, cur_inst}, hv ? {16'd0, hq[0]} : 32'd0);
      if (f) while (hq.size() > 1) void'(hq.pop_back());
      if (ret) begin
         void'(hq.pop_front());
         mstage = 0;
      end else if (fire) begin
         mstage++;
      end
      if (push && !byp) hq.push_back(w);
      mq = hq;
   endtask

   // Monitor: each retirement must match the oldest predicted retirement.
   always @(negedge clk) begin
      if (inst_done) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done: got inst_done with word %0h, expected none", cur_inst);
         end else begin
            chk("retired_inst", {16'd0, cur_inst}, {16'd0, sbq.pop_front()});
         end
      end
   end

   initial begin
      logic [15:0] w;
      #1 reset = 1'b1;
      #2;
      chk("rst_cur_valid", {31'd0, cur_valid}, 32'd0);
      chk("rst_count", {30'd0, queue_count}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_cur_inst", {16'd0, cur_inst}, 32'd0);
      chk("rst_cur_stage", {30'd0, cur_stage}, 32'd0);
      chk("rst_last", {31'd0, cur_last_stage}, 32'd0);
      chk("rst_pre", {31'd0, cur_pre_stage}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;

      // single stage
      step(1'b1, 16'h8123, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      // branch-call: two stages
      step(1'b1, 16'h0F10, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      // call src with repeats: stage 0,0,0,1
      step(1'b1, 16'h2040, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      // fill past depth, then pop while pushing, then drain
      for (int i = 0; i < 4; i++) step(1'b1, 16'h8000 + 16'(i), 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("full_count", {30'd0, queue_count}, 32'd3);
      chk("full_ready", {31'd0, in_ready}, 32'd0);
      step(1'b1, 16'h8010, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      // throughput and pointer wrap: one single-stage word per cycle
      for (int i = 0; i < 12; i++) step(1'b1, 16'h9000 + 16'(i), 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      // flush with head mid-call and in_valid high
      step(1'b1, 16'h0F22, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'h8001, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'h8002, 1'b1, 1'b0, 1'b0);
      step(1'b1, 16'h8003, 1'b0, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("flush_count", {30'd0, queue_count}, 32'd1);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      // asynchronous reset mid-call at stage 1
      step(1'b1, 16'h0F33, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0; sc_done = 1'b1; sc_repeat = 1'b0; flush = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, cur_valid}, 32'd0);
      chk("midrst_stage", {30'd0, cur_stage}, 32'd0);
      chk("midrst_done", {31'd0, inst_done}, 32'd0);
      chk("midrst_count", {30'd0, queue_count}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; sc_done = 1'b0;
      mq.delete();
      mstage = 0;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         case ($urandom_range(0, 2))
            0:       w = 16'($urandom);
            1:       w = {4'h0, 4'hF, 8'($urandom)};
            default: w = {10'b0010000001, 6'($urandom)};
         endcase
         step($urandom_range(0, 9) < 6, w, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
      end
      for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
